// File: rtl/calc_pkg.sv
// calc_pkg: key codes, keypad scanner states and row-priority helper shared by the calculator blocks
package calc_pkg;
    localparam logic [3:0] TECLA_A         = 4'hA;
    localparam logic [3:0] TECLA_B         = 4'hB;
    localparam logic [3:0] TECLA_C         = 4'hC;
    localparam logic [3:0] TECLA_D         = 4'hD;
    localparam logic [3:0] TECLA_ASTERISCO = 4'hE;
    localparam logic [3:0] TECLA_NUMERAL   = 4'hF;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} estado_teclado_t;

    function automatic logic [1:0] fila_activa(input logic [3:0] filas);
        return !filas[0] ? 2'd0 : !filas[1] ? 2'd1 : !filas[2] ? 2'd2 : 2'd3;
    endfunction
endpackage

// File: rtl/decodificador_tecla.sv
// decodificador_tecla: maps a keypad (column, row) position to its calculator code
module decodificador_tecla
    import calc_pkg::*;
(
    input  logic [1:0] col,
    input  logic [1:0] fila,
    output logic [3:0] codigo
);
    localparam logic [3:0] MAPA [16] = '{
        4'h1,            4'h2, 4'h3,          TECLA_A,
        4'h4,            4'h5, 4'h6,          TECLA_B,
        4'h7,            4'h8, 4'h9,          TECLA_C,
        TECLA_ASTERISCO, 4'h0, TECLA_NUMERAL, TECLA_D
    };
    assign codigo = MAPA[{fila, col}];
endmodule

// File: rtl/teclado_scanner.sv
// teclado_scanner: 4x4 keypad column scanner with press/release debounce and one strobe per press
module teclado_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [3:0] numero_traducido,
    output logic       tecla_valida
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_COUNT + 1);

    estado_teclado_t estado, estado_n;
    logic [DW-1:0] div;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [1:0] col, col_n, fila, fila_n;
    logic [3:0] codigo;
    logic muestra, hay_fila, cnt_lleno;

    assign muestra   = div == DW'(SCAN_DIV - 1);
    assign hay_fila  = ~&filas;
    assign cnt_inc   = (cnt == CW'(DEBOUNCE_COUNT)) ? cnt : cnt + 1'b1;
    assign cnt_lleno = cnt_inc == CW'(DEBOUNCE_COUNT);
    assign columnas  = ~(4'b0001 << col);
    // reset gating keeps a pending EMIT from strobing in the reset cycle
    assign tecla_valida = (estado == EMIT) && !reset;

    decodificador_tecla u_decodificador (.col(col), .fila(fila_n), .codigo(codigo));

    always_comb begin
        estado_n = estado;
        cnt_n    = cnt;
        col_n    = col;
        fila_n   = fila;
        case (estado)
            SCAN: if (muestra) begin
                if (hay_fila) begin
                    fila_n   = fila_activa(filas);
                    cnt_n    = cnt_inc;
                    estado_n = cnt_lleno ? EMIT : DEBOUNCE;
                end else col_n = col + 1'b1;
            end
            DEBOUNCE: if (muestra) begin
                if (!filas[fila]) begin
                    cnt_n    = cnt_inc;
                    estado_n = cnt_lleno ? EMIT : DEBOUNCE;
                end else begin
                    estado_n = SCAN;
                    cnt_n    = '0;
                    col_n    = col + 1'b1;
                end
            end
            EMIT: begin
                estado_n = WAIT_RELEASE;
                cnt_n    = '0;
            end
            WAIT_RELEASE: if (muestra) begin
                if (hay_fila) cnt_n = '0;
                else if (cnt_lleno) begin
                    estado_n = SCAN;
                    cnt_n    = '0;
                    col_n    = col + 1'b1;
                end else cnt_n = cnt_inc;
            end
            default: estado_n = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado           <= SCAN;
            div              <= '0;
            cnt              <= '0;
            col              <= '0;
            fila             <= '0;
            numero_traducido <= '0;
        end else begin
            estado <= estado_n;
            div    <= (muestra || estado == EMIT) ? '0 : div + 1'b1;
            cnt    <= cnt_n;
            col    <= col_n;
            fila   <= fila_n;
            if (estado_n == EMIT) numero_traducido <= codigo;
        end
    end
endmodule

// File: tb/tb_teclado_scanner.sv
// tb_teclado_scanner: directed and random keypad presses checked against a sample-level reference model
module tb_teclado_scanner;
    localparam int SD = 4;
    localparam int DC = 3;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] filas, columnas, numero_traducido;
    logic tecla_valida;
    logic [15:0] teclas;

    int n_checks = 0;
    int n_fail = 0;
    int pulsos = 0;
    logic [3:0] ultimo = '0;

    int m_col, m_t, m_fase, m_racha, m_fila;
    logic [3:0] m_codigo;

    teclado_scanner #(.SCAN_DIV(SD), .DEBOUNCE_COUNT(DC)) dut (
        .clk(clk), .reset(reset), .filas(filas), .columnas(columnas),
        .numero_traducido(numero_traducido), .tecla_valida(tecla_valida)
    );

    always #5 clk = ~clk;

    // physical keypad: a pressed key pulls its row low while its column is driven
    always_comb begin
        filas = 4'hF;
        for (int r = 0; r < 4; r++)
            if (|(teclas[r*4 +: 4] & ~columnas)) filas[r] = 1'b0;
    end

    always @(negedge clk) if (tecla_valida) begin
        pulsos++;
        ultimo = numero_traducido;
    end

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] codigo_de(input int r, input int c);
        string layout = "123A456B789C*0#D";
        byte ch = layout[r*4+c];
        if (ch >= "0" && ch <= "9") return 4'(ch - "0");
        if (ch >= "A" && ch <= "D") return 4'(ch - "A" + 10);
        return (ch == "*") ? 4'hE : 4'hF;
    endfunction

    task automatic modelo_reset();
        m_col = 0; m_t = 0; m_fase = 0; m_racha = 0; m_fila = 0; m_codigo = '0;
    endtask

    // phases: 0 scanning, 1 confirming press, 2 strobe, 3 confirming release
    task automatic modelo();
        logic [3:0] vistas;
        for (int r = 0; r < 4; r++) vistas[r] = teclas[r*4+m_col];
        if (reset) begin modelo_reset(); return; end
        if (m_fase == 2) begin m_fase = 3; m_racha = 0; m_t = 0; return; end
        if (m_t != SD-1) begin m_t++; return; end
        m_t = 0;
        if (m_fase == 0) begin
            if (vistas != 0) begin
                for (int r = 3; r >= 0; r--) if (vistas[r]) m_fila = r;
                m_racha = 1;
                m_fase = 1;
            end else m_col = (m_col + 1) % 4;
        end else if (m_fase == 1) begin
            if (vistas[m_fila]) m_racha++;
            else begin m_fase = 0; m_racha = 0; m_col = (m_col + 1) % 4; end
        end else begin
            m_racha = (vistas == 0) ? m_racha + 1 : 0;
            if (m_racha >= DC) begin m_fase = 0; m_racha = 0; m_col = (m_col + 1) % 4; end
        end
        if (m_fase == 1 && m_racha >= DC) begin
            m_fase = 2;
            m_codigo = codigo_de(m_fila, m_col);
        end
    endtask

    task automatic tick();
        logic [3:0] col_esp;
        #1;
        col_esp = ~(4'b0001 << m_col);
        verificar("columnas", columnas, col_esp);
        verificar("numero", numero_traducido, m_codigo);
        verificar("valida", tecla_valida, m_fase == 2 && !reset);
        modelo();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic escenario(input string tag, input int base, input int n_esp, input logic [3:0] cod);
        verificar({tag, "_pulsos"}, pulsos - base, n_esp);
        verificar({tag, "_codigo"}, ultimo, cod);
    endtask

    initial begin
        logic [3:0] rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        int base;
        reset = 1'b1;
        teclas = '0;
        modelo_reset();
        @(posedge clk);
        #1;
        tick();
        reset = 1'b0;
        verificar("reset_columnas", columnas, 4'b1110);
        verificar("reset_numero", numero_traducido, 4'h0);
        verificar("reset_valida", tecla_valida, 1'b0);
        for (int i = 0; i < 20; i++) begin
            verificar("rotacion", columnas, rot[(i/4)%4]);
            tick();
        end

        base = pulsos;
        teclas[5] = 1'b1;
        hold(40);
        teclas = '0;
        hold(30);
        escenario("tecla5", base, 1, 4'h5);

        base = pulsos;
        teclas[14] = 1'b1; hold(4);
        teclas[14] = 1'b0; hold(4);
        teclas[14] = 1'b1; hold(40);
        teclas = '0;
        hold(30);
        escenario("numeral", base, 1, 4'hF);

        base = pulsos;
        teclas[3] = 1'b1;
        teclas[11] = 1'b1;
        hold(40);
        teclas = '0;
        hold(30);
        escenario("prioridad", base, 1, 4'hA);

        base = pulsos;
        teclas[12] = 1'b1;
        hold(40);
        for (int i = 0; i < 6; i++) begin
            teclas[12] = ~teclas[12];
            hold(4);
        end
        teclas = '0;
        hold(30);
        escenario("rebote_suelta", base, 1, 4'hE);

        base = pulsos;
        teclas[8] = 1'b1;
        for (int i = 0; i < 100 && m_fase != 1; i++) tick();
        verificar("espera_debounce", m_fase, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        verificar("reset_medio_columnas", columnas, 4'b1110);
        tick();
        verificar("reset_medio_pulsos", pulsos - base, 0);
        hold(40);
        teclas = '0;
        hold(30);
        escenario("tecla7", base, 1, 4'h7);

        for (int n = 0; n < 40; n++) begin
            int k = $urandom_range(0, 15);
            teclas[k] = 1'b1;
            if ($urandom_range(0, 3) == 0) teclas[$urandom_range(0, 15)] = 1'b1;
            for (int i = $urandom_range(5, 60); i > 0; i--) begin
                if ($urandom_range(0, 7) == 0) teclas[k] = ~teclas[k];
                reset = ($urandom_range(0, 199) == 0);
                tick();
            end
            reset = 1'b0;
            teclas = '0;
            hold($urandom_range(0, 40));
        end
        hold(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
